// File: rtl/core_run_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : core_run_pkg                                             |
// | Shared types for the core run controller: the FSM state enum, the  |
// | end-of-run cause codes and the default-width trace entry layout.   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package core_run_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESET = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } run_state_e;

   localparam logic [1:0] CAUSE_NONE  = 2'd0;
   localparam logic [1:0] CAUSE_LIMIT = 2'd1;
   localparam logic [1:0] CAUSE_HALT  = 2'd2;

   localparam int TRACE_XLEN = 32;

   // One architectural register write as seen at the trace port.
   typedef struct packed {
      logic [4:0]            addr;
      logic [TRACE_XLEN-1:0] data;
   } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/core_run_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : core_run_ctrl_if                                       |
// | Bundles the core-facing signals (instr, register write-back) and   |
// | the trace drain port (valid/ready/addr/data/overflow).             |
// |   master : bench / core side   slave : core_run_ctrl               |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface core_run_ctrl_if #(
   parameter int XLEN = 32
);
   logic [31:0]     instr;
   logic            wb_valid;
   logic [4:0]      wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            trace_valid;
   logic            trace_ready;
   logic [4:0]      trace_addr;
   logic [XLEN-1:0] trace_data;
   logic            trace_overflow;

   modport master (
      output instr, wb_valid, wb_addr, wb_data, trace_ready,
      input  trace_valid, trace_addr, trace_data, trace_overflow
   );

   modport slave (
      input  instr, wb_valid, wb_addr, wb_data, trace_ready,
      output trace_valid, trace_addr, trace_data, trace_overflow
   );
endinterface
`default_nettype wire

// File: rtl/core_run_ctrl_trace_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : trace_fifo                                                |
// | Synchronous FIFO with flush. A push into a full FIFO is accepted   |
// | only when a pop happens on the same edge; otherwise it is dropped  |
// | and 'overflow' pulses for that cycle.                              |
// | Ports: clk, rst_n (async, active-low), flush, push/push_data,      |
// |        pop/pop_data, valid (non-empty), overflow (drop pulse).     |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module trace_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 16
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             flush,
   input  wire logic             push,
   input  wire logic [WIDTH-1:0] push_data,
   input  wire logic             pop,
   output logic      [WIDTH-1:0] pop_data,
   output logic                  valid,
   output logic                  overflow
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             empty;
   logic             full;
   logic             do_pop;
   logic             do_push;

   // Extra pointer bit distinguishes full from empty when indices match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign overflow = push && full && !do_pop;
   assign valid    = !empty;
   // Head is forced to zero when empty so the outputs have a defined value.
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : core_run_ctrl                                             |
// | Sequences the core reset, runs the core for at most MAX_CYCLES     |
// | cycles or until HALT_INSTR is presented, and reports the cause.    |
// | Optional trace FIFO of register writes: CORE_RUN_CTRL_TRACE_EN.    |
// | Ports: clk, rst (async, active-low), start, bus (slave modport:    |
// |        instr, wb_*, trace_*), core_rst_n, running, done,           |
// |        done_cause, cycle_count.                                    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module core_run_ctrl
   import core_run_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter int          RST_CYCLES  = 2,
   parameter int          MAX_CYCLES  = 10,
   parameter logic [31:0] HALT_INSTR  = 32'h0000_0073,
   parameter int          TRACE_DEPTH = 16
) (
   input  wire logic                              clk,
   input  wire logic                              rst,
   input  wire logic                              start,
   core_run_ctrl_if.slave                         bus,
   output logic                                   core_rst_n,
   output logic                                   running,
   output logic                                   done,
   output logic [1:0]                             done_cause,
   output logic [$clog2(MAX_CYCLES+1)-1:0]        cycle_count
);
   localparam int CW  = $clog2(MAX_CYCLES+1);
   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   run_state_e     state;
   run_state_e     state_nxt;
   logic [RCW-1:0] rst_cnt;
   logic [RCW-1:0] rst_cnt_nxt;
   logic [CW-1:0]  cycle_nxt;
   logic [1:0]     cause_nxt;
   logic           flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         rst_cnt     <= '0;
         cycle_count <= '0;
         done_cause  <= CAUSE_NONE;
         core_rst_n  <= 1'b0;
         running     <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         rst_cnt     <= rst_cnt_nxt;
         cycle_count <= cycle_nxt;
         done_cause  <= cause_nxt;
         // Status outputs are registered from the next state so they
         // change on the same edge as the state itself.
         core_rst_n  <= (state_nxt == RUN);
         running     <= (state_nxt == RUN);
         done        <= (state_nxt == DONE);
      end
   end

   always_comb begin
      state_nxt   = state;
      rst_cnt_nxt = rst_cnt;
      cycle_nxt   = cycle_count;
      cause_nxt   = done_cause;
      flush       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt   = RESET;
               rst_cnt_nxt = RCW'(RST_CYCLES-1);
               cycle_nxt   = '0;
               cause_nxt   = CAUSE_NONE;
               flush       = 1'b1;
            end
         end
         RESET: begin
            if (rst_cnt == '0) state_nxt = RUN;
            else               rst_cnt_nxt = rst_cnt - RCW'(1);
         end
         RUN: begin
            cycle_nxt = cycle_count + CW'(1);
            // HALT is checked first so it wins over the budget limit.
            if (bus.instr == HALT_INSTR) begin
               state_nxt = DONE;
               cause_nxt = CAUSE_HALT;
            end else if (cycle_count == CW'(MAX_CYCLES-1)) begin
               state_nxt = DONE;
               cause_nxt = CAUSE_LIMIT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef CORE_RUN_CTRL_TRACE_EN
   typedef struct packed {
      logic [4:0]      addr;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t push_entry;
   entry_t head_entry;
   logic   push;
   logic   fifo_valid;
   logic   drop;
   logic   overflow_r;

   // x0 writes carry no architectural state and are never traced.
   assign push       = (state == RUN) && bus.wb_valid && (bus.wb_addr != 5'd0);
   assign push_entry = {bus.wb_addr, bus.wb_data};

   trace_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (TRACE_DEPTH)
   ) u_trace_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .flush     (flush),
      .push      (push),
      .push_data (push_entry),
      .pop       (bus.trace_ready),
      .pop_data  (head_entry),
      .valid     (fifo_valid),
      .overflow  (drop)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       overflow_r <= 1'b0;
      else if (flush) overflow_r <= 1'b0;
      else if (drop)  overflow_r <= 1'b1;
   end

   assign bus.trace_valid    = fifo_valid;
   assign bus.trace_addr     = head_entry.addr;
   assign bus.trace_data     = head_entry.data;
   assign bus.trace_overflow = overflow_r;
`else
   logic unused_trace;
   assign unused_trace = ^{bus.wb_valid, bus.wb_addr, bus.wb_data, bus.trace_ready, flush};

   assign bus.trace_valid    = 1'b0;
   assign bus.trace_addr     = '0;
   assign bus.trace_data     = '0;
   assign bus.trace_overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_core_run_ctrl                                          |
// | Bench for core_run_ctrl. Expected run length/cause come from the   |
// | halt position and budget; trace contents come from a queue model.  |
// | Honours CORE_RUN_CTRL_TRACE_EN like the design does.               |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_core_run_ctrl;
   import core_run_pkg::*;

   localparam int          XLEN  = 32;
   localparam int          RST_C = 2;
   localparam int          MAX_C = 10;
   localparam int          DEPTH = 4;
   localparam logic [31:0] HALT  = 32'h0000_0073;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int          CW    = $clog2(MAX_C+1);
`ifdef CORE_RUN_CTRL_TRACE_EN
   localparam bit TRACE_ON = 1'b1;
`else
   localparam bit TRACE_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          core_rst_n;
   logic          running;
   logic          done;
   logic [1:0]    done_cause;
   logic [CW-1:0] cycle_count;

   core_run_ctrl_if #(.XLEN(XLEN)) bus ();

   core_run_ctrl #(
      .XLEN        (XLEN),
      .RST_CYCLES  (RST_C),
      .MAX_CYCLES  (MAX_C),
      .HALT_INSTR  (HALT),
      .TRACE_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .bus         (bus),
      .core_rst_n  (core_rst_n),
      .running     (running),
      .done        (done),
      .done_cause  (done_cause),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_bad = 0;
   trace_entry_t q[$];
   bit           exp_ovf = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_ctrl(input logic crn, input logic run, input logic dn,
                             input logic [1:0] cause, input int cnt);
      chk("core_rst_n", core_rst_n, crn);
      chk("running", running, run);
      chk("done", done, dn);
      chk("done_cause", done_cause, cause);
      chk("cycle_count", cycle_count, cnt);
   endtask

   task automatic check_trace();
      trace_entry_t h;
      h = (q.size() > 0) ? q[0] : '0;
      chk("trace_valid", bus.trace_valid, q.size() > 0);
      chk("trace_addr", bus.trace_addr, h.addr);
      chk("trace_data", bus.trace_data, h.data);
      chk("trace_overflow", bus.trace_overflow, exp_ovf);
   endtask

   // Apply inputs for the coming edge, advance the model across it, wait.
   task automatic drive_cycle(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                              input logic rdy, input bit run_phase);
      trace_entry_t e;
      bus.wb_valid    = wv;
      bus.wb_addr     = wa;
      bus.wb_data     = wd;
      bus.trace_ready = rdy;
      if ((q.size() > 0) && rdy) void'(q.pop_front());
      if (TRACE_ON && run_phase && wv && (wa != 5'd0)) begin
         e.addr = wa;
         e.data = wd;
         if (q.size() < DEPTH) q.push_back(e);
         else                  exp_ovf = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic rand_cycle(input bit run_phase);
      logic [4:0] wa;
      wa = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive_cycle(1'($urandom_range(0, 1)), wa, $urandom, ($urandom_range(0, 2) == 0), run_phase);
   endtask

   // mode 0: random traffic, 1: directed trace capture, 2: overflow sequence
   task automatic do_run(input int halt_at, input int mode);
      int         len;
      logic [1:0] cause;
      logic [31:0] ri;
      bit         hit;
      hit   = (halt_at >= 1) && (halt_at <= MAX_C);
      len   = hit ? halt_at : MAX_C;
      cause = hit ? CAUSE_HALT : CAUSE_LIMIT;
      bus.instr = NOP;
      start     = 1'b1;
      q.delete();
      exp_ovf   = 1'b0;
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      start = 1'b0;
      for (int r = 1; r <= RST_C; r++) begin
         check_ctrl(1'b0, 1'b0, 1'b0, CAUSE_NONE, 0);
         check_trace();
         if (mode == 0) start = ($urandom_range(0, 3) == 0);
         rand_cycle(1'b0);
      end
      for (int k = 1; k <= len; k++) begin
         check_ctrl(1'b1, 1'b1, 1'b0, CAUSE_NONE, k - 1);
         check_trace();
         ri = $urandom;
         if (ri == HALT) ri = NOP;
         bus.instr = (k == halt_at) ? HALT : ((mode == 0) ? ri : NOP);
         if (mode == 0) begin
            start = ($urandom_range(0, 3) == 0);
            rand_cycle(1'b1);
         end else if (mode == 1) begin
            case (k)
               1:       drive_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b1);
               2:       drive_cycle(1'b1, 5'd0, 32'h0000_0001, 1'b0, 1'b1);
               3:       drive_cycle(1'b1, 5'd7, 32'h0000_1234, 1'b0, 1'b1);
               default: drive_cycle(1'b0, 5'd3, 32'h0, 1'b0, 1'b1);
            endcase
         end else begin
            if (k <= 4)      drive_cycle(1'b1, 5'(k + 1), $urandom, 1'b0, 1'b1);
            else if (k == 5) drive_cycle(1'b1, 5'd9, $urandom, 1'b1, 1'b1);
            else if (k <= 7) drive_cycle(1'b1, 5'(k + 10), $urandom, 1'b0, 1'b1);
            else             drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
         end
      end
      start     = 1'b0;
      bus.instr = NOP;
      for (int d = 0; d < DEPTH + 4; d++) begin
         check_ctrl(1'b0, 1'b0, 1'b1, cause, len);
         check_trace();
         if (d < 3) rand_cycle(1'b0);
         else       drive_cycle(1'($urandom_range(0, 1)), 5'd4, $urandom, 1'b1, 1'b0);
      end
      check_trace();
   endtask

   initial begin
      rst             = 1'b0;
      start           = 1'b0;
      bus.instr       = NOP;
      bus.wb_valid    = 1'b0;
      bus.wb_addr     = 5'd0;
      bus.wb_data     = '0;
      bus.trace_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_ctrl(1'b0, 1'b0, 1'b0, CAUSE_NONE, 0);
      check_trace();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_cycle(1'b0);
         check_ctrl(1'b0, 1'b0, 1'b0, CAUSE_NONE, 0);
         check_trace();
      end

      do_run(0, 1);          // basic LIMIT run with directed trace writes
      do_run(4, 0);          // halt in the 4th RUN cycle
      do_run(MAX_C, 2);      // halt on the budget's last cycle, overflow traffic
      for (int n = 0; n < 8; n++) do_run($urandom_range(1, MAX_C + 3), 0);

      // Abort in the 3rd RUN cycle with an asynchronous reset.
      start = 1'b1;
      q.delete();
      exp_ovf = 1'b0;
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      start = 1'b0;
      for (int r = 0; r < RST_C; r++) rand_cycle(1'b0);
      drive_cycle(1'b1, 5'd6, 32'hCAFE_0001, 1'b0, 1'b1);
      drive_cycle(1'b1, 5'd8, 32'hCAFE_0002, 1'b0, 1'b1);
      check_ctrl(1'b1, 1'b1, 1'b0, CAUSE_NONE, 2);
      check_trace();
      #1 rst = 1'b0;
      q.delete();
      exp_ovf = 1'b0;
      #1;
      check_ctrl(1'b0, 1'b0, 1'b0, CAUSE_NONE, 0);
      check_trace();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_cycle(1'b0);
         check_ctrl(1'b0, 1'b0, 1'b0, CAUSE_NONE, 0);
         check_trace();
      end
      do_run($urandom_range(1, MAX_C + 3), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
